// File: rtl/truth_table_checker.sv
// Sweeps every input vector through a DUT and compares against a loaded table.
// Optional FIRST_FAIL_CAPTURE_EN latches the first mismatching vector.
module truth_table_checker #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ld_en,
  input  logic [IN_W-1:0]  ld_addr,
  input  logic [OUT_W-1:0] ld_data,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W:0]    err_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             first_fail_valid,
  output logic [IN_W-1:0]  first_fail_addr
`endif
);

  localparam int DEPTH = 2 ** IN_W;
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [IN_W-1:0]    r_dut_in;
  logic [IN_W:0]      r_err;
  logic               r_pass;
  logic               r_done;
  logic [OUT_W-1:0]   r_table [DEPTH];

  logic               w_accept;
  logic               w_last;
  logic               w_miss;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_dut_in == {IN_W{1'b1}});
  assign w_miss   = (r_state == S_CHECK) &&
                    (dut_out != r_table[r_dut_in]);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == '0) w_next = S_CHECK;
      S_CHECK:  w_next = w_last ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The table survives reset so a sweep after reset reuses it.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && ld_en) r_table[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_dut_in <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_accept) begin
        r_dut_in <= '0;
        r_err    <= '0;
        r_pass   <= 1'b0;
        r_cnt    <= CNT_INIT;
      end
      if (r_state == S_SETTLE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_CHECK) begin
        if (w_miss) r_err <= r_err + 1'b1;
        if (!w_last) begin
          r_dut_in <= r_dut_in + 1'b1;
          r_cnt    <= CNT_INIT;
        end
      end
      if (r_state == S_DONE) begin
        r_pass   <= (r_err == '0);
        r_dut_in <= '0;
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic            r_ff_valid;
  logic [IN_W-1:0] r_ff_addr;

  always_ff @(posedge clk) begin
    if (!rst_n || w_accept) begin
      r_ff_valid <= 1'b0;
      r_ff_addr  <= '0;
    end else if (w_miss && !r_ff_valid) begin
      r_ff_valid <= 1'b1;
      r_ff_addr  <= r_dut_in;
    end
  end

  assign first_fail_valid = r_ff_valid;
  assign first_fail_addr  = r_ff_addr;
`endif

  assign dut_in    = r_dut_in;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

endmodule
